// File: rtl/drop_ctrl_fsm.sv
// drop_ctrl_fsm
// Registered baggage-drop controller. A four-state machine (IDLE, HOT, DROP,
// DONE) runs on drop_en and a compare of the current temperature against the
// limit. It drives four 7-segment digits (COLD / blinking HOT / drop) and a
// timed drop actuator pulse. A drop completion is flagged for one cycle.
//
// Ports:
//   clk             in   1    clock, rising edge
//   rst             in   1    synchronous reset, active high
//   drop_en         in   1    drop request/enable (level)
//   t_act           in   T_W  current temperature, unsigned
//   t_lim           in   T_W  temperature limit, unsigned
//   seven_seg1..4   out  7    digit segment codes, registered
//   drop_activated  out  1    actuator drive, registered
//   drop_done       out  1    one-cycle pulse on normal drop completion
//
// Every output is a register loaded from a decode of the next state. An input
// sampled at one edge is therefore visible right after that same edge.
module drop_ctrl_fsm #(
  parameter int T_W         = 16,
  parameter int HYST        = 2,
  parameter int DROP_CYCLES = 8,
  parameter int BLINK_HALF  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           drop_en,
  input  logic [T_W-1:0] t_act,
  input  logic [T_W-1:0] t_lim,
  output logic [6:0]     seven_seg1,
  output logic [6:0]     seven_seg2,
  output logic [6:0]     seven_seg3,
  output logic [6:0]     seven_seg4,
  output logic           drop_activated,
  output logic           drop_done
);

  typedef enum logic [1:0] {S_IDLE, S_HOT, S_DROP, S_DONE} state_t;

  localparam int DCW = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
  localparam int BCW = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;
  localparam logic [DCW-1:0] DROP_LAST  = DCW'(DROP_CYCLES - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_HALF - 1);
  localparam logic [T_W:0]   HYST_W     = (T_W + 1)'(HYST);

  // Segment codes, digit 1 first.
  localparam logic [27:0] CODE_COLD  = {7'h39, 7'h5C, 7'h38, 7'h5E};
  localparam logic [27:0] CODE_HOT   = {7'h00, 7'h76, 7'h5C, 7'h78};
  localparam logic [27:0] CODE_DROP  = {7'h5E, 7'h50, 7'h5C, 7'h73};
  localparam logic [27:0] CODE_BLANK = 28'h0;

  state_t         r_state;
  logic [DCW-1:0] r_drop_cnt;
  logic [BCW-1:0] r_blink_cnt;
  logic           r_blink_vis;
  logic [27:0]    r_segs;
  logic           r_drop_act;
  logic           r_drop_done;

  state_t         w_state_next;
  logic [DCW-1:0] w_drop_cnt_next;
  logic [BCW-1:0] w_blink_cnt_next;
  logic           w_blink_vis_next;
  logic [27:0]    w_segs_next;
  logic           w_hot;
  logic           w_cool;

  assign w_hot  = t_act > t_lim;
  // One extra bit so t_act + HYST cannot wrap and falsely look cool.
  assign w_cool = ({1'b0, t_act} + HYST_W) <= {1'b0, t_lim};

  always_comb begin
    w_state_next     = r_state;
    w_drop_cnt_next  = r_drop_cnt;
    w_blink_cnt_next = r_blink_cnt;
    w_blink_vis_next = r_blink_vis;

    case (r_state)
      S_IDLE: begin
        if (drop_en) w_state_next = w_hot ? S_HOT : S_DROP;
      end
      S_HOT: begin
        if (w_cool) w_state_next = S_DROP;
      end
      S_DROP: begin
        // Overheat abort beats completion, even on the last drop cycle.
        if (w_hot)                         w_state_next = S_HOT;
        else if (r_drop_cnt == DROP_LAST)  w_state_next = S_DONE;
        else                               w_drop_cnt_next = r_drop_cnt + DCW'(1);
      end
      default: begin
        // DONE: temperature ignored, only drop_en release leaves.
      end
    endcase

    if (!drop_en) w_state_next = S_IDLE;

    // Any state change restarts both timers with the HOT phase visible.
    if (w_state_next != r_state) begin
      w_drop_cnt_next  = '0;
      w_blink_cnt_next = '0;
      w_blink_vis_next = 1'b1;
    end else if (r_state == S_HOT) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_next = '0;
        w_blink_vis_next = ~r_blink_vis;
      end else begin
        w_blink_cnt_next = r_blink_cnt + BCW'(1);
      end
    end

    case (w_state_next)
      S_HOT:   w_segs_next = w_blink_vis_next ? CODE_HOT : CODE_BLANK;
      S_DROP:  w_segs_next = CODE_DROP;
      S_DONE:  w_segs_next = CODE_DROP;
      default: w_segs_next = CODE_COLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drop_cnt  <= '0;
      r_blink_cnt <= '0;
      r_blink_vis <= 1'b1;
      r_segs      <= CODE_COLD;
      r_drop_act  <= 1'b0;
      r_drop_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_drop_cnt  <= w_drop_cnt_next;
      r_blink_cnt <= w_blink_cnt_next;
      r_blink_vis <= w_blink_vis_next;
      r_segs      <= w_segs_next;
      r_drop_act  <= (w_state_next == S_DROP);
      r_drop_done <= (r_state == S_DROP) && (w_state_next == S_DONE);
    end
  end

  assign seven_seg1     = r_segs[27:21];
  assign seven_seg2     = r_segs[20:14];
  assign seven_seg3     = r_segs[13:7];
  assign seven_seg4     = r_segs[6:0];
  assign drop_activated = r_drop_act;
  assign drop_done      = r_drop_done;

endmodule

// File: tb/tb_drop_ctrl_fsm.sv
module tb_drop_ctrl_fsm;

  typedef enum logic [1:0] {D_COLD, D_HOT, D_DROP, D_BLANK} disp_t;

  typedef struct {
    int          rep;
    logic        rst;
    logic        en;
    logic [15:0] ta;
    logic [15:0] tl;
    disp_t       disp;
    logic        act;
    logic        done;
  } vec_t;

  typedef struct {
    int    id;
    disp_t disp;
    logic  act;
    logic  done;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        drop_en;
  logic [15:0] t_act;
  logic [15:0] t_lim;
  logic [6:0]  seven_seg1, seven_seg2, seven_seg3, seven_seg4;
  logic        drop_activated;
  logic        drop_done;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];
  vec_t tbl[25];

  drop_ctrl_fsm #(
    .T_W(16), .HYST(2), .DROP_CYCLES(8), .BLINK_HALF(4)
  ) dut (
    .clk(clk), .rst(rst), .drop_en(drop_en), .t_act(t_act), .t_lim(t_lim),
    .seven_seg1(seven_seg1), .seven_seg2(seven_seg2),
    .seven_seg3(seven_seg3), .seven_seg4(seven_seg4),
    .drop_activated(drop_activated), .drop_done(drop_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] disp_code(disp_t d);
    case (d)
      D_COLD:  return {7'h39, 7'h5C, 7'h38, 7'h5E};
      D_HOT:   return {7'h00, 7'h76, 7'h5C, 7'h78};
      D_DROP:  return {7'h5E, 7'h50, 7'h5C, 7'h73};
      default: return 28'h0;
    endcase
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input logic r, input logic en, input logic [15:0] ta,
                       input logic [15:0] tl, input disp_t d, input logic act,
                       input logic done, input int id);
    exp_t e;
    logic [27:0] segs;
    @(negedge clk);
    rst = r; drop_en = en; t_act = ta; t_lim = tl;
    exp_q.push_back('{id, d, act, done});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    segs = {seven_seg1, seven_seg2, seven_seg3, seven_seg4};
    checks++;
    if (segs !== disp_code(e.disp)) begin
      failures++;
      $display("FAIL step %0d digits: got %07h want %07h", e.id, segs, disp_code(e.disp));
    end
    checks++;
    if (drop_activated !== e.act) begin
      failures++;
      $display("FAIL step %0d drop_activated: got %b want %b", e.id, drop_activated, e.act);
    end
    checks++;
    if (drop_done !== e.done) begin
      failures++;
      $display("FAIL step %0d drop_done: got %b want %b", e.id, drop_done, e.done);
    end
    checks++;
    if (drop_activated === 1'b1 && drop_done === 1'b1) begin
      failures++;
      $display("FAIL step %0d act_and_done: got both 1 want exclusive", e.id);
    end
    $display("step %0d rst=%b en=%b t_act=%h t_lim=%h digits=%07h act=%b done=%b",
             e.id, r, en, ta, tl, segs, drop_activated, drop_done);
  endtask

  initial begin
    int step = 0;
    rst = 1'b1; drop_en = 1'b0; t_act = 16'd50; t_lim = 16'd100;

    //            rep rst en  t_act     t_lim     disp     act   done
    // reset and idle
    tbl[0]  = '{2, 1'b1, 1'b0, 16'd50,  16'd100, D_COLD,  1'b0, 1'b0};
    tbl[1]  = '{2, 1'b0, 1'b0, 16'd50,  16'd100, D_COLD,  1'b0, 1'b0};
    // normal drop: 8 active cycles, done pulse, DONE holds until release
    tbl[2]  = '{8, 1'b0, 1'b1, 16'd50,  16'd100, D_DROP,  1'b1, 1'b0};
    tbl[3]  = '{1, 1'b0, 1'b1, 16'd50,  16'd100, D_DROP,  1'b0, 1'b1};
    tbl[4]  = '{2, 1'b0, 1'b1, 16'd200, 16'd100, D_DROP,  1'b0, 1'b0};
    tbl[5]  = '{1, 1'b0, 1'b0, 16'd200, 16'd100, D_COLD,  1'b0, 1'b0};
    // HOT blink 4 visible / 4 blank, hysteresis band then exit
    tbl[6]  = '{4, 1'b0, 1'b1, 16'd120, 16'd100, D_HOT,   1'b0, 1'b0};
    tbl[7]  = '{4, 1'b0, 1'b1, 16'd120, 16'd100, D_BLANK, 1'b0, 1'b0};
    tbl[8]  = '{1, 1'b0, 1'b1, 16'd120, 16'd100, D_HOT,   1'b0, 1'b0};
    tbl[9]  = '{1, 1'b0, 1'b1, 16'd99,  16'd100, D_HOT,   1'b0, 1'b0};
    tbl[10] = '{1, 1'b0, 1'b1, 16'd98,  16'd100, D_DROP,  1'b1, 1'b0};
    // overheat in DROP cycle 3 aborts to HOT
    tbl[11] = '{2, 1'b0, 1'b1, 16'd50,  16'd100, D_DROP,  1'b1, 1'b0};
    tbl[12] = '{1, 1'b0, 1'b1, 16'd101, 16'd100, D_HOT,   1'b0, 1'b0};
    tbl[13] = '{1, 1'b0, 1'b1, 16'd101, 16'd100, D_HOT,   1'b0, 1'b0};
    // drop_en release in DROP cycle 5
    tbl[14] = '{5, 1'b0, 1'b1, 16'd50,  16'd100, D_DROP,  1'b1, 1'b0};
    tbl[15] = '{1, 1'b0, 1'b0, 16'd50,  16'd100, D_COLD,  1'b0, 1'b0};
    // reset mid-DROP, then a full drop proves the counter restarted at 0
    tbl[16] = '{2, 1'b0, 1'b1, 16'd50,  16'd100, D_DROP,  1'b1, 1'b0};
    tbl[17] = '{1, 1'b1, 1'b1, 16'd50,  16'd100, D_COLD,  1'b0, 1'b0};
    tbl[18] = '{8, 1'b0, 1'b1, 16'd50,  16'd100, D_DROP,  1'b1, 1'b0};
    tbl[19] = '{1, 1'b0, 1'b1, 16'd50,  16'd100, D_DROP,  1'b0, 1'b1};
    tbl[20] = '{1, 1'b0, 1'b0, 16'd50,  16'd100, D_COLD,  1'b0, 1'b0};
    // full-scale values: equal is not hot, and cool must not wrap
    tbl[21] = '{1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, D_DROP, 1'b1, 1'b0};
    tbl[22] = '{1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFE, D_HOT,  1'b0, 1'b0};
    tbl[23] = '{3, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, D_HOT,  1'b0, 1'b0};
    tbl[24] = '{1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, D_COLD, 1'b0, 1'b0};

    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < tbl[i].rep; k++) begin
        apply(tbl[i].rst, tbl[i].en, tbl[i].ta, tbl[i].tl,
              tbl[i].disp, tbl[i].act, tbl[i].done, step);
        step++;
      end
    end

    // Long HOT dwell: phase toggles every 4 cycles starting visible.
    for (int k = 0; k < 16; k++) begin
      apply(1'b0, 1'b1, 16'd200, 16'd100,
            (((k / 4) % 2) == 0) ? D_HOT : D_BLANK, 1'b0, 1'b0, step);
      step++;
    end
    apply(1'b0, 1'b0, 16'd200, 16'd100, D_COLD, 1'b0, 1'b0, step);
    step++;

    // A drop restarted from HOT after cooling still lasts 8 cycles.
    apply(1'b0, 1'b1, 16'd200, 16'd100, D_HOT, 1'b0, 1'b0, step);
    step++;
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 1'b1, 16'd10, 16'd100, D_DROP, 1'b1, 1'b0, step);
      step++;
    end
    apply(1'b0, 1'b1, 16'd10, 16'd100, D_DROP, 1'b0, 1'b1, step);
    step++;
    apply(1'b0, 1'b0, 16'd10, 16'd100, D_COLD, 1'b0, 1'b0, step);
    step++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
